// File: rtl/adc_sched_pkg.sv
// Shared types and width helpers for the XADC conversion scheduler and its arbiter.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_EOC = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Bits needed for a counter that must hold the value max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_rr_arbiter.sv
// Round-robin first-set search starting at ptr+1 with wrap; purely combinational.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx
);

  logic [IW-1:0] cand;

  // Scan farthest-to-nearest so the nearest set bit after ptr is written last.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win     = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = IW'((32'(ptr) + k) % N_REQ);
      if (req[cand]) win_idx = cand;
    end
    if (|req) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Shares one XADC between N_REQ requesters: CONVST pulse, EOC wait with timeout,
// 2^AVG_LOG2 oversampling and round-robin grant.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned NB_DATA     = 12,
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned CONVST_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_valid,
  output logic               o_err,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_adc_trigger,
  input  logic               i_adc_done,
  input  logic               i_adc_busy,
  input  logic [NB_DATA-1:0] i_adc_val
);

  localparam int unsigned IW    = idx_w(N_REQ);
  localparam int unsigned AW    = NB_DATA + AVG_LOG2;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;
  localparam int unsigned CW    = cnt_w(CONVST_CYC);
  localparam int unsigned TW    = cnt_w(TIMEOUT_CYC);
  localparam int unsigned SW    = cnt_w(NSAMP);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONVST_CYC - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(NSAMP - 1);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    ccnt;
  logic [TW-1:0]    tcnt;
  logic [SW-1:0]    scnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    sum_next;
  logic [N_REQ-1:0] win;
  logic [IW-1:0]    win_idx;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req    (i_req),
    .ptr    (ptr),
    .win    (win),
    .win_idx(win_idx)
  );

  assign sum_next = acc + AW'(i_adc_val);

  // Result and valid are loaded on the transition into DONE so they are visible
  // while DONE is the current state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(N_REQ - 1);
      ccnt          <= '0;
      tcnt          <= '0;
      scnt          <= '0;
      acc           <= '0;
      o_gnt         <= '0;
      o_valid       <= '0;
      o_err         <= 1'b0;
      o_data        <= '0;
      o_adc_trigger <= 1'b0;
    end else begin
      o_valid <= '0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|i_req && !i_adc_busy) begin
            o_gnt         <= win;
            ptr           <= win_idx;
            o_adc_trigger <= 1'b1;
            ccnt          <= '0;
            state         <= START;
          end
        end
        START: begin
          if (ccnt == CONV_LAST) begin
            o_adc_trigger <= 1'b0;
            tcnt          <= '0;
            state         <= WAIT_EOC;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        WAIT_EOC: begin
          if (i_adc_done) begin
            acc <= sum_next;
            if (scnt == SAMP_LAST) begin
              o_valid <= o_gnt;
              o_data  <= sum_next[AW-1:AVG_LOG2];
              state   <= DONE;
            end else begin
              scnt          <= scnt + 1'b1;
              o_adc_trigger <= 1'b1;
              ccnt          <= '0;
              state         <= START;
            end
          end else if (tcnt == TIME_LAST) begin
            o_valid <= o_gnt;
            o_err   <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          acc   <= '0;
          scnt  <= '0;
          tcnt  <= '0;
          ccnt  <= '0;
          o_gnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Self-checking bench: table vectors, hand-written corner sequences and random
// transactions against a behavioural XADC model and round-robin/averaging reference.
module tb_adc_conv_scheduler;

  localparam int unsigned NR   = 2;
  localparam int unsigned AVG  = 2;
  localparam int unsigned CONV = 4;
  localparam int unsigned TMO  = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  valid;
  logic        err;
  logic [11:0] data;
  logic        trig;
  logic        adc_done;
  logic        busy;
  logic [11:0] adc_val;

  always #4 clk = ~clk;

  adc_conv_scheduler #(
    .NB_DATA    (12),
    .N_REQ      (NR),
    .AVG_LOG2   (AVG),
    .CONVST_CYC (CONV),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_valid      (valid),
    .o_err        (err),
    .o_data       (data),
    .o_adc_trigger(trig),
    .i_adc_done   (adc_done),
    .i_adc_busy   (busy),
    .i_adc_val    (adc_val)
  );

  typedef struct packed {
    logic [1:0]  req;
    logic [47:0] s;
    logic        en;
    logic [5:0]  dly;
    logic [1:0]  gnt;
    logic [11:0] data;
    logic        err;
  } vec_t;

  vec_t tbl [9];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // XADC model state
  int unsigned sq[$];
  bit          eoc_en = 1'b0;
  int unsigned eoc_dly = 30;
  bit          inject_stray = 1'b0;
  int          countdown = 0;
  bit          prev_m = 1'b0;

  // Monitor state
  bit          prev_t = 1'b0;
  int unsigned cur_w = 0;
  int unsigned pulses = 0;
  int unsigned bad_w = 0;
  int unsigned since_fall = 0;
  int unsigned n_valid = 0;

  // Reference model state
  int unsigned ptr_m;
  int unsigned last_data;

  // EOC arrives eoc_dly cycles after CONVST falls; optional stray EOCs while CONVST is high.
  initial begin
    adc_done = 1'b0;
    adc_val  = '0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (!rst_n) begin
        countdown = 0;
      end else begin
        if (prev_m && !trig && eoc_en) begin
          countdown = int'(eoc_dly);
        end else if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            adc_done = 1'b1;
            adc_val  = (sq.size() > 0) ? 12'(sq.pop_front()) : 12'd0;
          end
        end
        if (inject_stray && trig) begin
          adc_done = 1'b1;
          adc_val  = 12'd4000;
        end
      end
      prev_m = trig;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (trig) begin
        cur_w++;
      end else if (prev_t) begin
        pulses++;
        if (cur_w != CONV) bad_w++;
        cur_w = 0;
      end
      if (prev_t && !trig) since_fall = 0;
      else since_fall++;
      if (valid != '0) n_valid++;
      prev_t = trig;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input int unsigned last, input logic [NR-1:0] mask);
    int unsigned c;
    for (int unsigned k = 1; k <= NR; k++) begin
      c = (last + k) % NR;
      if (((32'(mask) >> c) & 32'd1) == 32'd1) return c;
    end
    return last;
  endfunction

  function automatic int unsigned avg4(input logic [47:0] s);
    int unsigned sum;
    sum = 32'(s[11:0]) + 32'(s[23:12]) + 32'(s[35:24]) + 32'(s[47:36]);
    return sum / (1 << AVG);
  endfunction

  task automatic load(input logic [47:0] s);
    sq.delete();
    sq.push_back(32'(s[11:0]));
    sq.push_back(32'(s[23:12]));
    sq.push_back(32'(s[35:24]));
    sq.push_back(32'(s[47:36]));
    pulses = 0;
    bad_w  = 0;
  endtask

  task automatic start_req(input logic [1:0] mask, input logic [47:0] s, input bit en,
                           input int unsigned dly);
    load(s);
    eoc_en  = en;
    eoc_dly = dly;
    req     = mask;
  endtask

  task automatic finish_txn(input string tag, input logic [1:0] e_gnt, input logic [11:0] e_data,
                            input bit e_err, input bit drop);
    int unsigned cyc;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (valid == '0 && cyc < 1000);
    if (drop) req = '0;
    check({tag, "_valid"}, 32'(valid), 32'(e_gnt));
    check({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_data"}, 32'(data), 32'(e_data));
    check({tag, "_pulses"}, pulses, e_err ? 32'd1 : 32'd4);
    check({tag, "_width"}, bad_w, 0);
    if (e_err) check({tag, "_tmo_cyc"}, since_fall, TMO);
    @(negedge clk); #1;
    check({tag, "_gnt_clr"}, 32'(gnt), 0);
    check({tag, "_vld_clr"}, 32'(valid), 0);
  endtask

  initial begin
    logic [47:0] s;
    logic [1:0]  mask;
    bit          en;
    int unsigned w, exp_d, dly, bc, cyc, vcount;
    bit          seen;

    rst_n = 1'b0;
    req   = '0;
    busy  = 1'b0;

    tbl[0] = '{2'b01, {12'd105, 12'd102, 12'd101, 12'd100}, 1'b1, 6'd30, 2'b01, 12'd102, 1'b0};
    tbl[1] = '{2'b11, {12'd40, 12'd30, 12'd20, 12'd10}, 1'b1, 6'd30, 2'b10, 12'd25, 1'b0};
    tbl[2] = '{2'b11, {12'd4095, 12'd4095, 12'd4095, 12'd4095}, 1'b1, 6'd20, 2'b01, 12'd4095, 1'b0};
    tbl[3] = '{2'b10, {12'd11, 12'd10, 12'd9, 12'd8}, 1'b1, 6'd10, 2'b10, 12'd9, 1'b0};
    tbl[4] = '{2'b01, {12'd1, 12'd1, 12'd1, 12'd1}, 1'b0, 6'd30, 2'b01, 12'd9, 1'b1};
    tbl[5] = '{2'b11, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b1, 6'd30, 2'b10, 12'd2, 1'b0};
    tbl[6] = '{2'b11, {12'd11, 12'd7, 12'd7, 12'd7}, 1'b1, 6'd49, 2'b01, 12'd8, 1'b0};
    tbl[7] = '{2'b11, {12'd1, 12'd1, 12'd1, 12'd1}, 1'b1, 6'd50, 2'b10, 12'd8, 1'b1};
    tbl[8] = '{2'b01, {12'd4094, 12'd4095, 12'd4095, 12'd4095}, 1'b1, 6'd5, 2'b01, 12'd4094, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_data", 32'(data), 0);
    check("rst_trig", 32'(trig), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    ptr_m     = NR - 1;
    last_data = 0;

    for (int i = 0; i < 9; i++) begin
      start_req(tbl[i].req, tbl[i].s, tbl[i].en, 32'(tbl[i].dly));
      finish_txn($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].data, tbl[i].err, 1'b1);
      ptr_m     = (tbl[i].gnt == 2'b10) ? 1 : 0;
      last_data = 32'(tbl[i].data);
    end

    // EOCs while CONVST is high must not be counted
    inject_stray = 1'b1;
    start_req(2'b01, {12'd80, 12'd70, 12'd60, 12'd50}, 1'b1, 20);
    finish_txn("stray", 2'b01, 12'd65, 1'b0, 1'b1);
    inject_stray = 1'b0;
    ptr_m = 0;
    last_data = 65;

    // Requests held continuously: grants alternate
    eoc_en  = 1'b1;
    eoc_dly = 25;
    for (int i = 0; i < 4; i++) begin
      s = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
      load(s);
      if (i == 0) req = 2'b11;
      w     = rr_pick(ptr_m, 2'b11);
      exp_d = avg4(s);
      finish_txn($sformatf("rr%0d", i), 2'(32'd1 << w), 12'(exp_d), 1'b0, bit'(i == 3));
      ptr_m     = w;
      last_data = exp_d;
    end

    // Busy converter holds off arbitration
    busy = 1'b1;
    start_req(2'b01, {12'd500, 12'd400, 12'd300, 12'd200}, 1'b1, 30);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (gnt != '0) seen = 1'b1;
    end
    check("busy_hold", 32'(seen), 0);
    busy = 1'b0;
    @(negedge clk); #1;
    check("busy_gnt", 32'(gnt), 32'd1);
    finish_txn("busy", 2'b01, 12'd350, 1'b0, 1'b1);
    ptr_m = 0;
    last_data = 350;

    for (int t = 0; t < 20; t++) begin
      mask = 2'($urandom_range(1, 3));
      en   = ($urandom_range(0, 5) != 0);
      dly  = $urandom_range(1, 45);
      bc   = $urandom_range(0, 3);
      s = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
      busy = (bc != 0);
      start_req(mask, s, en, dly);
      repeat (bc) begin
        @(negedge clk); #1;
      end
      busy  = 1'b0;
      w     = rr_pick(ptr_m, mask);
      exp_d = en ? avg4(s) : last_data;
      finish_txn($sformatf("rnd%0d", t), 2'(32'd1 << w), 12'(exp_d), !en, 1'b1);
      ptr_m     = w;
      last_data = exp_d;
    end

    // Reset while waiting for EOC
    start_req(2'b01, {12'd900, 12'd900, 12'd900, 12'd900}, 1'b1, 40);
    cyc = 0;
    while (trig == 1'b0 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    while (trig == 1'b1 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("rst_reach_wait", 32'(cyc < 200), 1);
    repeat (5) begin
      @(negedge clk); #1;
    end
    vcount = n_valid;
    rst_n = 1'b0;
    #1;
    check("rst_mid_trig", 32'(trig), 0);
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_valid", 32'(valid), 0);
    check("rst_mid_data", 32'(data), 0);
    req = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk); #1;
    end
    check("rst_no_result", n_valid, vcount);
    ptr_m = NR - 1;
    start_req(2'b11, {12'd3, 12'd2, 12'd1, 12'd0}, 1'b1, 15);
    finish_txn("post_rst", 2'(32'd1 << rr_pick(ptr_m, 2'b11)), 12'd1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
